coin_accumulator: RTL and testbench
===================================

Name: coin_accumulator

Overview:
- Upstream credit engine for the vending lab. It takes raw coin and button inputs, accumulates credit in colones, and handles purchase, change and refund.
- It drives the 12-bit binary amount consumed directly by the 4-digit coin display decoder.
- The `cantidad` output is always a multiple of 100 in the range 0..MAX_AMT, so the display shows every value the engine produces.

Parameters:
- MAX_AMT, 1500, credit ceiling; multiple of 100, ≤ 4095
- PRICE_A, 500, price of product 0
- PRICE_B, 800, price of product 1
- PRICE_C, 1200, price of product 2
- PULSE_GAP, 4, cycles between change_100 pulses (≥2)
- TIMEOUT_CYC, 1000, idle cycles in ACCUM before automatic refund

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- coin_100  in  1  raw level, coin 100 inserted (asynchronous)
- coin_500  in  1  raw level, coin 500 inserted (asynchronous)
- buy  in  1  raw level, purchase request (asynchronous)
- cancel  in  1  raw level, refund request (asynchronous)
- sel  in  2  product select, sampled on buy edge; 3 = invalid
- cantidad  out  12  current credit, binary, to display decoder
- dispense  out  1  one-cycle pulse, product released
- product  out  2  selection latched at dispense; held until next dispense
- change_100  out  1  one-cycle pulse per 100 returned
- reject_coin  out  1  one-cycle pulse, coin not accepted
- busy  out  1  high in DISPENSE and CHANGE

Behaviour:
- Reset (asynchronous, rst_n=0): all outputs 0; state IDLE; synchronizers and timers cleared.
- Reset mid-operation: credit is discarded and no change is paid. This is decided behaviour.
- Input conditioning:
  - coin_100, coin_500, buy and cancel each pass through a 2-flop synchronizer followed by a rising-edge detector.
  - An event acts 3 cycles after the raw rise. `cantidad` updates on that same edge.
  - `sel` is sampled through its own 2-flop synchronizer, aligned with buy.
- States:
  - IDLE: cantidad = 0.
  - ACCUM: credit > 0, accepting events.
  - DISPENSE: one cycle.
  - CHANGE: paying out credit.
- Per-cycle priority in IDLE/ACCUM: cancel > buy > coin.
  - A coin edge that loses to cancel or buy in the same cycle is rejected (reject_coin=1).
- Coin rules:
  - An accepted coin adds 100 or 500 to cantidad. IDLE→ACCUM on first credit.
  - Both coin edges in the same cycle: add 600 if the result is ≤ MAX_AMT; otherwise reject both (single reject_coin pulse, credit unchanged).
  - Single coin: if cantidad + value > MAX_AMT, reject and leave credit unchanged. Exact MAX_AMT is accepted.
  - Coin edges while busy=1 are always rejected.
- Buy rules:
  - sel=3: ignored.
  - price(sel) > cantidad: ignored; credit unchanged, stay in state.
  - Otherwise →DISPENSE. In DISPENSE: dispense=1, product=sel, cantidad -= price.
  - Next state is CHANGE if the remainder > 0, else IDLE.
- Cancel: in ACCUM →CHANGE. In IDLE it is ignored.
- Timeout:
  - A counter in ACCUM resets on any accepted coin or any buy/cancel edge.
  - On reaching TIMEOUT_CYC-1 →CHANGE.
  - The counter is held at 0 outside ACCUM.
- CHANGE:
  - The first change_100 pulse occurs on the cycle after entry. Each pulse decrements cantidad by 100.
  - Pulses are spaced exactly PULSE_GAP cycles apart.
  - The pulse that makes cantidad = 0 also transitions to IDLE.
  - buy and cancel edges are ignored in CHANGE.
- Widths and invariants:
  - All arithmetic is 12-bit unsigned; no wrap is possible because of the ceiling checks.
  - cantidad mod 100 = 0 at all times.
  - busy is combinational from state.

Test Plan:
- Reset, then coin_500, coin_500, coin_100 -> cantidad steps 500, 1000, 1100, with each update 3 cycles after the raw rise; reject_coin never asserted.
- Credit 1100, sel=1, buy -> dispense pulse, product=1, cantidad 300; then 3 change_100 pulses PULSE_GAP=4 cycles apart, cantidad 200/100/0; state IDLE.
- Credit 1400, coin_500 -> reject_coin pulse, cantidad stays 1400. Then coin_100 -> 1500. Then coin_100 -> rejected.
- Credit 700, sel=2 buy (1200) -> no dispense, cantidad 700. Same cycle as a cancel edge with a coin_100 edge -> coin rejected, CHANGE pays 7 pulses.
- Credit 500, no activity for TIMEOUT_CYC cycles -> automatic CHANGE, 5 pulses, cantidad 0. A coin_100 during CHANGE -> reject_coin, credit unaffected.
- Credit 1000, rst_n low during the 2nd change pulse -> all outputs 0 immediately (asynchronously); after release, state IDLE, no further change_100.

Source files
------------

// File: rtl/coin_accumulator.sv
// Credit engine for the vending lab: conditions raw coin/button inputs, accumulates
// credit in colones, and sequences purchase, change payout and refund.
module coin_accumulator #(
    parameter int unsigned MAX_AMT     = 1500,
    parameter int unsigned PRICE_A     = 500,
    parameter int unsigned PRICE_B     = 800,
    parameter int unsigned PRICE_C     = 1200,
    parameter int unsigned PULSE_GAP   = 4,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        coin_100,
    input  logic        coin_500,
    input  logic        buy,
    input  logic        cancel,
    input  logic [1:0]  sel,
    output logic [11:0] cantidad,
    output logic        dispense,
    output logic [1:0]  product,
    output logic        change_100,
    output logic        reject_coin,
    output logic        busy
);

    localparam int unsigned GW = $clog2(PULSE_GAP);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC);
    localparam logic [12:0] MAX13 = 13'(MAX_AMT);
    localparam logic [11:0] PA = 12'(PRICE_A);
    localparam logic [11:0] PB = 12'(PRICE_B);
    localparam logic [11:0] PC = 12'(PRICE_C);

    typedef enum logic [1:0] {IDLE, ACCUM, DISPENSE, CHANGE} state_t;

    state_t          state_q, state_d;
    logic [3:0]      sync1_q, sync2_q, prev_q;   // {cancel, buy, coin_500, coin_100}
    logic [1:0]      sel1_q, sel2_q;
    logic [11:0]     amt_q, amt_d;
    logic [1:0]      prod_q, prod_d;
    logic            disp_q, disp_d, chg_q, chg_d, rej_q, rej_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [TW-1:0]   to_q, to_d;

    logic [3:0]      edge_w;
    logic            c100_e, c500_e, buy_e, cancel_e, coin_any, coin_fits;
    logic [12:0]     coin_val, coin_sum;
    logic [11:0]     price;

    assign edge_w   = sync2_q & ~prev_q;
    assign c100_e   = edge_w[0];
    assign c500_e   = edge_w[1];
    assign buy_e    = edge_w[2];
    assign cancel_e = edge_w[3];
    assign coin_any = c100_e | c500_e;

    assign coin_val  = (c100_e ? 13'd100 : 13'd0) + (c500_e ? 13'd500 : 13'd0);
    assign coin_sum  = {1'b0, amt_q} + coin_val;
    assign coin_fits = (coin_sum <= MAX13);

    always_comb begin
        case (sel2_q)
            2'd0:    price = PA;
            2'd1:    price = PB;
            default: price = PC;
        endcase
    end

    always_comb begin
        state_d = state_q;
        amt_d   = amt_q;
        prod_d  = prod_q;
        disp_d  = 1'b0;
        chg_d   = 1'b0;
        rej_d   = 1'b0;
        gap_d   = '0;
        to_d    = '0;
        case (state_q)
            IDLE, ACCUM: begin
                // Priority cancel > buy > coin; a coin sharing its cycle with either is refused.
                rej_d = coin_any & (cancel_e | buy_e | ~coin_fits);
                if (cancel_e) begin
                    if (state_q == ACCUM) state_d = CHANGE;
                end else if (buy_e) begin
                    if (sel2_q != 2'd3 && price <= amt_q) begin
                        state_d = DISPENSE;
                        amt_d   = amt_q - price;
                        prod_d  = sel2_q;
                        disp_d  = 1'b1;
                    end
                end else if (coin_any && coin_fits) begin
                    amt_d   = coin_sum[11:0];
                    state_d = ACCUM;
                end else if (state_q == ACCUM) begin
                    if (to_q == TW'(TIMEOUT_CYC - 1)) state_d = CHANGE;
                    else                              to_d    = to_q + 1'b1;
                end
            end
            DISPENSE: begin
                rej_d   = coin_any;
                state_d = (amt_q != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                rej_d = coin_any;
                // gap_q is zero on entry, so the first pulse lands one cycle in.
                if (gap_q == '0) begin
                    chg_d = 1'b1;
                    amt_d = amt_q - 12'd100;
                    gap_d = GW'(PULSE_GAP - 1);
                    if (amt_q == 12'd100) state_d = IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            sel1_q  <= '0;
            sel2_q  <= '0;
            amt_q   <= '0;
            prod_q  <= '0;
            disp_q  <= 1'b0;
            chg_q   <= 1'b0;
            rej_q   <= 1'b0;
            gap_q   <= '0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            sync1_q <= {cancel, buy, coin_500, coin_100};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            sel1_q  <= sel;
            sel2_q  <= sel1_q;
            amt_q   <= amt_d;
            prod_q  <= prod_d;
            disp_q  <= disp_d;
            chg_q   <= chg_d;
            rej_q   <= rej_d;
            gap_q   <= gap_d;
            to_q    <= to_d;
        end
    end

    assign cantidad    = amt_q;
    assign dispense    = disp_q;
    assign product     = prod_q;
    assign change_100  = chg_q;
    assign reject_coin = rej_q;
    assign busy        = (state_q == DISPENSE) || (state_q == CHANGE);

endmodule

// File: tb/tb_coin_accumulator.sv
// Scoreboard bench for coin_accumulator: stimulus queues expected output events,
// a negedge monitor pops and compares every observed event.
module tb_coin_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        coin_100 = 1'b0, coin_500 = 1'b0, buy = 1'b0, cancel = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic [11:0] cantidad;
    logic        dispense, change_100, reject_coin, busy;
    logic [1:0]  product;

    coin_accumulator #(
        .MAX_AMT(1500), .PRICE_A(500), .PRICE_B(800), .PRICE_C(1200),
        .PULSE_GAP(4), .TIMEOUT_CYC(1000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .coin_100(coin_100), .coin_500(coin_500),
        .buy(buy), .cancel(cancel), .sel(sel), .cantidad(cantidad),
        .dispense(dispense), .product(product), .change_100(change_100),
        .reject_coin(reject_coin), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int amt;
        bit disp;
        int prod;
        bit chg;
        bit rej;
    } ev_t;

    ev_t q[$];
    ev_t got, want;
    int  checks = 0, errors = 0;
    int  exp_prod = 0;
    int  prev_amt = 0;

    function automatic void expect_ev(int c, int amt, bit d, bit ch, bit r);
        ev_t e;
        e.cyc = c; e.amt = amt; e.disp = d; e.prod = exp_prod; e.chg = ch; e.rej = r;
        q.push_back(e);
    endfunction

    // An event is any credit change or any output pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_amt = 0;
        end else if (int'(cantidad) != prev_amt || dispense || change_100 || reject_coin) begin
            got.cyc = cyc; got.amt = int'(cantidad); got.disp = dispense;
            got.prod = int'(product); got.chg = change_100; got.rej = reject_coin;
            prev_amt = int'(cantidad);
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got cyc=%0d amt=%0d disp=%0b prod=%0d chg=%0b rej=%0b, expected no event",
                         got.cyc, got.amt, got.disp, got.prod, got.chg, got.rej);
            end else begin
                want = q.pop_front();
                if (got.cyc != want.cyc || got.amt != want.amt || got.disp != want.disp ||
                    got.prod != want.prod || got.chg != want.chg || got.rej != want.rej) begin
                    errors++;
                    $display("FAIL event: got cyc=%0d amt=%0d disp=%0b prod=%0d chg=%0b rej=%0b, expected cyc=%0d amt=%0d disp=%0b prod=%0d chg=%0b rej=%0b",
                             got.cyc, got.amt, got.disp, got.prod, got.chg, got.rej,
                             want.cyc, want.amt, want.disp, want.prod, want.chg, want.rej);
                end
            end
        end
    end

    task automatic chk(input string name, input int g, input int w);
        checks++;
        if (g != w) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, g, w);
        end
    endtask

    task automatic press(input bit c1, input bit c5, input bit b, input bit cn,
                         input int at, output int c);
        @(negedge clk);
        while (cyc < at) @(negedge clk);
        coin_100 = c1; coin_500 = c5; buy = b; cancel = cn;
        c = cyc;
    endtask

    task automatic release_all();
        repeat (4) @(negedge clk);
        coin_100 = 1'b0; coin_500 = 1'b0; buy = 1'b0; cancel = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int c, cc, d;
        int t3_amt[6];
        t3_amt = '{500, 1000, 1100, 1200, 1300, 1400};

        repeat (3) @(negedge clk);
        chk("reset_cantidad", int'(cantidad), 0);
        chk("reset_dispense", int'(dispense), 0);
        chk("reset_product", int'(product), 0);
        chk("reset_change", int'(change_100), 0);
        chk("reset_reject", int'(reject_coin), 0);
        chk("reset_busy", int'(busy), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Accumulate 500, 1000, 1100.
        press(0, 1, 0, 0, 0, c); expect_ev(c + 3, 500, 0, 0, 0);  release_all();
        press(0, 1, 0, 0, 0, c); expect_ev(c + 3, 1000, 0, 0, 0); release_all();
        press(1, 0, 0, 0, 0, c); expect_ev(c + 3, 1100, 0, 0, 0); release_all();

        // Buy product 1 (800) from 1100, then three change pulses.
        sel = 2'd1;
        press(0, 0, 1, 0, 0, c);
        exp_prod = 1;
        expect_ev(c + 3, 300, 1, 0, 0);
        expect_ev(c + 5, 200, 0, 1, 0);
        expect_ev(c + 9, 100, 0, 1, 0);
        expect_ev(c + 13, 0, 0, 1, 0);
        release_all();
        chk("busy_in_change", int'(busy), 1);
        wait_to(c + 16);
        chk("idle_after_buy_busy", int'(busy), 0);
        chk("idle_after_buy_amt", int'(cantidad), 0);

        // Ceiling: build 1400, 500 rejected, 100 reaches 1500, next 100 rejected.
        for (int i = 0; i < 6; i++) begin
            press(i >= 2, i < 2, 0, 0, 0, c); expect_ev(c + 3, t3_amt[i], 0, 0, 0); release_all();
        end
        press(0, 1, 0, 0, 0, c); expect_ev(c + 3, 1400, 0, 0, 1); release_all();
        press(1, 0, 0, 0, 0, c); expect_ev(c + 3, 1500, 0, 0, 0); release_all();
        press(1, 0, 0, 0, 0, c); expect_ev(c + 3, 1500, 0, 0, 1); release_all();
        press(0, 0, 0, 1, 0, c);
        for (int k = 0; k < 15; k++) expect_ev(c + 4 + 4 * k, 1400 - 100 * k, 0, 1, 0);
        release_all();
        wait_to(c + 4 + 56 + 3);

        // 700 credit: unaffordable buy ignored; cancel with simultaneous coin.
        press(0, 1, 0, 0, 0, c); expect_ev(c + 3, 500, 0, 0, 0); release_all();
        press(1, 0, 0, 0, 0, c); expect_ev(c + 3, 600, 0, 0, 0); release_all();
        press(1, 0, 0, 0, 0, c); expect_ev(c + 3, 700, 0, 0, 0); release_all();
        sel = 2'd2;
        press(0, 0, 1, 0, 0, c); release_all();
        chk("unaffordable_buy_amt", int'(cantidad), 700);
        chk("unaffordable_buy_busy", int'(busy), 0);
        press(1, 0, 0, 1, 0, c);
        expect_ev(c + 3, 700, 0, 0, 1);
        for (int k = 0; k < 7; k++) expect_ev(c + 4 + 4 * k, 600 - 100 * k, 0, 1, 0);
        release_all();
        wait_to(c + 4 + 24 + 3);

        // Timeout refund of 500 with a coin refused mid-payout.
        press(0, 1, 0, 0, 0, c);
        cc = c + 3;
        expect_ev(cc, 500, 0, 0, 0);
        expect_ev(cc + 1001, 400, 0, 1, 0);
        expect_ev(cc + 1003, 400, 0, 0, 1);
        for (int k = 1; k < 5; k++) expect_ev(cc + 1001 + 4 * k, 400 - 100 * k, 0, 1, 0);
        release_all();
        press(1, 0, 0, 0, cc + 1000, d);
        release_all();
        wait_to(cc + 1001 + 16 + 3);
        chk("timeout_done_busy", int'(busy), 0);

        // Reset during the second change pulse of a 1000 refund.
        press(0, 1, 0, 0, 0, c); expect_ev(c + 3, 500, 0, 0, 0);  release_all();
        press(0, 1, 0, 0, 0, c); expect_ev(c + 3, 1000, 0, 0, 0); release_all();
        press(0, 0, 0, 1, 0, c);
        expect_ev(c + 4, 900, 0, 1, 0);
        expect_ev(c + 8, 800, 0, 1, 0);
        release_all();
        wait_to(c + 8);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_cantidad", int'(cantidad), 0);
        chk("async_rst_change", int'(change_100), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_product", int'(product), 0);
        chk("async_rst_dispense", int'(dispense), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        exp_prod = 0;
        repeat (40) @(negedge clk);
        chk("post_rst_cantidad", int'(cantidad), 0);
        chk("post_rst_busy", int'(busy), 0);

        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
